// File: rtl/rfsoc_pl_pkg.sv
// Shared constants and types for the ADC-to-PS capture path.
// Lane count and capture length width are fixed by the 128-to-32 bit serializer.
package rfsoc_pl_pkg;
    localparam int ADC_W  = 128;
    localparam int PS_W   = 32;
    localparam int LANES  = ADC_W / PS_W;
    localparam int LANE_W = $clog2(LANES);
    localparam int LEN_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FLUSH,
        ST_DONE
    } cap_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port (data appears the cycle after i_rd_en).
// Pointers carry an extra wrap bit so full/empty come straight from a pointer compare.
module sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_rd_en,
    output logic [WIDTH-1:0]        o_rd_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_rd_data = r_rd_data;

    // A pop at full frees the slot the concurrent write lands in.
    assign w_do_rd = i_rd_en && !o_empty;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end
endmodule

// File: rtl/adc_capture_to_ps.sv
// Captures a fixed number of 128-bit ADC beats into a FIFO and serializes them
// as 32-bit words towards the PS, low lane first, with tlast on the final word.
module adc_capture_to_ps
    import rfsoc_pl_pkg::*;
#(
    parameter int PS_AXIS_WIDTH = PS_W,
    parameter int ADC_WIDTH     = ADC_W,
    parameter int FIFO_DEPTH    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic [LEN_W-1:0]         capture_len,
    input  logic [ADC_WIDTH-1:0]     s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [PS_AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output cap_state_e               o_dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    cap_state_e          r_state;
    logic [LEN_W-1:0]    r_remaining;
    logic [LANE_W-1:0]   r_lane;
    logic                r_tvalid;
    logic                r_tlast;
    logic                r_last_beat;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;

    logic [ADC_WIDTH-1:0] w_fifo_rd_data;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [AW:0]          w_fifo_count;
    logic [AW:0]          w_total;
    logic                 w_active;
    logic                 w_handshake;
    logic                 w_release;
    logic                 w_pop;
    logic                 w_room;
    logic                 w_beat_in;
    logic                 w_wr;
    logic                 w_drop;
    logic [PS_AXIS_WIDTH-1:0] w_word;

    assign w_active    = (r_state == ST_CAPTURE) || (r_state == ST_FLUSH);
    assign w_handshake = r_tvalid && m_axis_tready;
    assign w_release   = w_handshake && (r_lane == LANE_W'(LANES - 1));
    assign w_pop       = w_active && !w_fifo_empty && (!r_tvalid || w_release);

    // The beat held in the serializer still occupies one of the FIFO_DEPTH buffer slots.
    assign w_total   = w_fifo_count + {{AW{1'b0}}, r_tvalid};
    assign w_room    = (!w_fifo_full && (w_total != FULL_CNT)) || w_release;
    assign w_beat_in = (r_state == ST_CAPTURE) && s_axis_tvalid && (r_remaining != '0);
    assign w_wr      = w_beat_in && w_room;
    assign w_drop    = w_beat_in && !w_room;

    sync_fifo #(
        .WIDTH (ADC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr),
        .i_wr_data (s_axis_tdata),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_rd_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    always_comb begin
        w_word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_word = w_fifo_rd_data[i*PS_AXIS_WIDTH +: PS_AXIS_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_overflow <= 1'b0;
                        if (capture_len != '0) begin
                            r_remaining <= capture_len;
                            r_busy      <= 1'b1;
                            r_state     <= ST_CAPTURE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    // Dropped beats still count so an overflowing capture terminates.
                    if (w_wr || w_drop) begin
                        r_remaining <= r_remaining - 1'b1;
                    end
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (r_remaining == '0) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_fifo_empty && (!r_tvalid || (w_handshake && r_tlast))) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A beat is the last one when it leaves the FIFO alone and no more beats can arrive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tvalid    <= 1'b0;
            r_lane      <= '0;
            r_tlast     <= 1'b0;
            r_last_beat <= 1'b0;
        end else if (w_pop) begin
            r_tvalid    <= 1'b1;
            r_lane      <= '0;
            r_tlast     <= 1'b0;
            r_last_beat <= (w_fifo_count == (AW+1)'(1)) && (r_remaining == '0);
        end else if (w_handshake) begin
            r_lane  <= r_lane + 1'b1;
            r_tlast <= r_last_beat && (r_lane == LANE_W'(LANES - 2));
            if (w_release) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = w_word;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;
    assign overflow      = r_overflow;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_adc_capture_to_ps.sv
// Randomized bench for adc_capture_to_ps: beats are turned into an expected word
// queue (4 words per stored beat, low lane first) and compared against the PS stream.
module tb_adc_capture_to_ps;
    import rfsoc_pl_pkg::*;

    localparam int DEPTH      = 64;
    localparam int RDY_ONE    = 0;
    localparam int RDY_TOGGLE = 1;
    localparam int RDY_RAND   = 2;
    localparam int RDY_ZERO   = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         arm = 1'b0;
    logic [15:0]  capture_len = '0;
    logic [127:0] s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic         m_axis_tlast;
    logic         busy;
    logic         done;
    logic         overflow;
    cap_state_e   dbg_state;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rdy_mode = RDY_ONE;
    int words = 0;
    int tlast_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int tlast_cyc = 0;
    int arm_cyc = 0;
    int first_tv_cyc = -1;
    bit saw_tvalid = 1'b0;

    adc_capture_to_ps dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .capture_len   (capture_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .o_dbg_state   (dbg_state)
    );

    // clock / cycle count
    always #2 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // PS-side ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                RDY_ONE:    m_axis_tready = 1'b1;
                RDY_TOGGLE: m_axis_tready = ~m_axis_tready;
                RDY_RAND:   m_axis_tready = 1'($urandom_range(0, 1));
                default:    m_axis_tready = 1'b0;
            endcase
        end
    end

    // scoreboard: every accepted word is matched against the expected queue
    always @(negedge clk) begin
        if (m_axis_tvalid && !saw_tvalid) begin
            saw_tvalid   = 1'b1;
            first_tv_cyc = cyc;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            words++;
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("word", m_axis_tdata, mon_exp);
                check("tlast", 32'(m_axis_tlast), 32'(exp_q.size() == 0));
            end
            if (m_axis_tlast) begin
                tlast_cnt++;
                tlast_cyc = cyc;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", 32'(busy), 32'd0);
        end
    end

    task automatic drive_arm(input int len);
        @(posedge clk);
        #1;
        arm         = 1'b1;
        capture_len = 16'(len);
        arm_cyc     = cyc;
        @(posedge clk);
        #1;
        arm = 1'b0;
    endtask

    function automatic logic [127:0] make_beat(input int idx, input bit rand_data);
        logic [127:0] b;
        if (rand_data) b = {$urandom, $urandom, $urandom, $urandom};
        else b = {16'(idx), 16'd3, 16'(idx), 16'd2, 16'(idx), 16'd1, 16'(idx), 16'd0};
        return b;
    endfunction

    task automatic run_capture(input int len, input int extra, input bit gaps,
                               input int mode, input bit rearm, input bit rand_data);
        int sent;
        int stored;
        int d0;
        logic [127:0] beat;
        words        = 0;
        tlast_cnt    = 0;
        saw_tvalid   = 1'b0;
        first_tv_cyc = -1;
        d0           = done_cnt;
        rdy_mode     = mode;
        // With the PS stalled for the whole capture nothing drains, so only DEPTH beats fit.
        stored = (mode == RDY_ZERO && len > DEPTH) ? DEPTH : len;
        drive_arm(len);
        sent = 0;
        while (sent < len + extra) begin
            s_axis_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            beat = make_beat(sent, rand_data);
            s_axis_tdata = beat;
            if (s_axis_tvalid) begin
                if (sent < stored) begin
                    for (int j = 0; j < 4; j++) exp_q.push_back(beat[j*32 +: 32]);
                end
                sent++;
                if (rearm && sent == 2) begin
                    arm         = 1'b1;
                    capture_len = 16'(len + 5);
                end
            end
            @(posedge clk);
            #1;
            arm = 1'b0;
        end
        s_axis_tvalid = 1'b0;
        if (mode == RDY_ZERO) rdy_mode = RDY_ONE;
        for (int t = 0; t < 4000 && done_cnt == d0; t++) @(posedge clk);
        @(negedge clk);
        check("done_seen", 32'(done_cnt - d0), 32'd1);
        check("word_count", 32'(words), 32'(stored * 4));
        check("words_left", 32'(exp_q.size()), 32'd0);
        check("tlast_count", 32'(tlast_cnt), 32'(stored > 0));
        check("overflow", 32'(overflow), 32'(stored < len));
        if (stored > 0) begin
            check("done_after_tlast", 32'(done_cyc - tlast_cyc), 32'd1);
        end else begin
            check("done_latency_len0", 32'(done_cyc - arm_cyc), 32'd1);
            check("tvalid_never", 32'(saw_tvalid), 32'd0);
        end
        if (!gaps && stored > 0) check("first_valid_lat", 32'(first_tv_cyc - arm_cyc), 32'd3);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("state_idle", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({pfx, "_tlast"}, 32'(m_axis_tlast), 32'd0);
        check({pfx, "_tdata"}, m_axis_tdata, 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
        check({pfx, "_done"}, 32'(done), 32'd0);
        check({pfx, "_overflow"}, 32'(overflow), 32'd0);
        check({pfx, "_s_tready"}, 32'(s_axis_tready), 32'd1);
        check({pfx, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic run_reset_midway();
        int d0;
        words      = 0;
        tlast_cnt  = 0;
        d0         = done_cnt;
        rdy_mode   = RDY_ONE;
        drive_arm(4);
        for (int i = 0; i < 4; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = make_beat(i, 1'b1);
            for (int j = 0; j < 4; j++) exp_q.push_back(s_axis_tdata[j*32 +: 32]);
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        for (int t = 0; t < 200 && words < 5; t++) @(posedge clk);
        rdy_mode = RDY_ZERO;
        #1;
        rst = 1'b0;
        check("rst_words_before", 32'(words), 32'd5);
        @(posedge clk);
        @(negedge clk);
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
        check("no_tlast_after_rst", 32'(tlast_cnt), 32'd0);
        exp_q.delete();
        run_capture(1, 0, 1'b0, RDY_ONE, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_capture(3, 0, 1'b0, RDY_ONE, 1'b0, 1'b0);
        run_capture(2, 0, 1'b0, RDY_TOGGLE, 1'b0, 1'b0);
        run_capture(100, 0, 1'b0, RDY_ZERO, 1'b0, 1'b0);
        run_capture(0, 0, 1'b0, RDY_ONE, 1'b0, 1'b0);
        run_reset_midway();
        run_capture(3, 5, 1'b0, RDY_ONE, 1'b1, 1'b0);
        run_capture(64, 0, 1'b0, RDY_ZERO, 1'b0, 1'b1);

        for (int k = 0; k < 10; k++) begin
            run_capture($urandom_range(1, 64), $urandom_range(0, 3), 1'b1,
                        (k % 2 == 0) ? RDY_RAND : RDY_TOGGLE, 1'b0, 1'b1);
        end
        for (int k = 0; k < 2; k++) begin
            run_capture($urandom_range(65, 120), 0, 1'($urandom_range(0, 1)), RDY_ZERO, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
